// File: rtl/ula_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : ula_arbiter_if
// Purpose : request/response channels for two requesters plus the shared ALU port.
// Rev     : 1.0
// ============================================================================
interface ula_arbiter_if;
  logic        req0_valid;
  logic [3:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [3:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;

  logic        rsp0_valid;
  logic [31:0] rsp0_s;
  logic        rsp0_z;
  logic        rsp0_ready;
  logic        rsp1_valid;
  logic [31:0] rsp1_s;
  logic        rsp1_z;
  logic        rsp1_ready;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_s;
  logic        alu_z;

  // Requester/ALU environment side
  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp0_s, rsp0_z,
    output rsp0_ready,
    input  rsp1_valid, rsp1_s, rsp1_z,
    output rsp1_ready,
    input  alu_a, alu_b, alu_op,
    output alu_s, alu_z
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp0_s, rsp0_z,
    input  rsp0_ready,
    output rsp1_valid, rsp1_s, rsp1_z,
    input  rsp1_ready,
    output alu_a, alu_b, alu_op,
    input  alu_s, alu_z
  );
endinterface
`default_nettype wire

// File: rtl/ula_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ula_arbiter
// Purpose : arbitrates two requesters onto one combinational ALU (IDLE/EXEC/RESP).
//           Define ULA_ARB_RR_EN for round-robin; default is fixed priority (req0 wins).
// Rev     : 1.0
// ============================================================================
module ula_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  ula_arbiter_if.slave bus
);

  localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] s0_q, s0_d;
  logic [31:0] s1_q, s1_d;
  logic        z0_q, z0_d;
  logic        z1_q, z1_d;

  logic        sel;
  logic        accept;

  // rst_n gates acceptance so ready stays low for the whole reset interval
  assign accept = rst_n && (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);

`ifdef ULA_ARB_RR_EN
  logic prio_q, prio_d;

  always_comb begin
    sel = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      sel = prio_q;
    end
  end

  assign prio_d = accept ? ~sel : prio_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  assign sel = ~bus.req0_valid;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    z0_d    = z0_q;
    z1_d    = z1_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          gnt_d   = sel;
          op_d    = sel ? bus.req1_op : bus.req0_op;
          a_d     = sel ? bus.req1_a  : bus.req0_a;
          b_d     = sel ? bus.req1_b  : bus.req0_b;
          cnt_d   = 4'd0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == LAT_LAST) begin
          cnt_d   = 4'd0;
          state_d = RESP;
          if (gnt_q) begin
            s1_d = bus.alu_s;
            z1_d = bus.alu_z;
          end else begin
            s0_d = bus.alu_s;
            z0_d = bus.alu_z;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        if (gnt_q ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      cnt_q   <= 4'd0;
      s0_q    <= 32'd0;
      s1_q    <= 32'd0;
      z0_q    <= 1'b0;
      z1_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      z0_q    <= z0_d;
      z1_q    <= z1_d;
    end
  end

  assign bus.req0_ready = accept && !sel;
  assign bus.req1_ready = accept &&  sel;

  assign bus.rsp0_valid = (state_q == RESP) && !gnt_q;
  assign bus.rsp1_valid = (state_q == RESP) &&  gnt_q;
  assign bus.rsp0_s     = s0_q;
  assign bus.rsp0_z     = z0_q;
  assign bus.rsp1_s     = s1_q;
  assign bus.rsp1_z     = z1_q;

  assign bus.alu_a  = (state_q == EXEC) ? a_q  : 32'd0;
  assign bus.alu_b  = (state_q == EXEC) ? b_q  : 32'd0;
  assign bus.alu_op = (state_q == EXEC) ? op_q : 4'd0;

endmodule
`default_nettype wire

// File: doc/ula_arbiter.md
ULA_ARBITER -- requirements
Module: ula_arbiter

Interface
REQ-001 The block SHALL have parameter ALU_LAT, default 1, giving the number of cycles operands are held stable on the ALU port before the result is sampled (legal 1..15).
REQ-002 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have ports reqN_valid input 1, reqN_op input 4, reqN_a input 32, reqN_b input 32, reqN_ready output 1 (N=0,1): the request channel.
REQ-005 The block SHALL have ports rspN_valid output 1, rspN_s output 32, rspN_z output 1, rspN_ready input 1 (N=0,1): the response channel.
REQ-006 The block SHALL have ports alu_a output 32, alu_b output 32, alu_op output 4, alu_s input 32, alu_z input 1: the shared combinational 32-bit ALU (op codes 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT signed, 1100 NOR, 0011 XOR, others give 0).

Function
REQ-007 The block SHALL implement FSM states IDLE, EXEC, RESP.
REQ-008 In IDLE, if at least one reqN_valid is high, the block SHALL grant one requester, assert only its reqN_ready combinationally in that cycle, latch its op/a/b, and go to EXEC on the edge.
REQ-009 reqN_ready SHALL be low in EXEC and RESP, and in IDLE for the non-granted requester.
REQ-010 In EXEC, alu_a/alu_b/alu_op SHALL be driven from the latched registers; a latency counter SHALL count ALU_LAT cycles, then the edge ending the last one SHALL capture alu_s/alu_z into the result registers and go to RESP.
REQ-011 Outside EXEC, alu_a, alu_b, alu_op SHALL be driven to 0.
REQ-012 In RESP, rspG_valid (G = granted index) SHALL be high with rspG_s/rspG_z stable; the other rsp valid SHALL be low.
REQ-013 When rspG_valid and rspG_ready are both high on an edge, the block SHALL return to IDLE; no new request is accepted in that same cycle.
REQ-014 rspG_valid SHALL rise exactly ALU_LAT cycles after the acceptance edge.
REQ-015 The block SHALL not alter latched operands if the requester changes its inputs after acceptance.
REQ-016 rspN_s/rspN_z SHALL hold the last captured result for that requester when rspN_valid is low.
REQ-017 A request held valid while the block is busy SHALL be served on a later IDLE cycle and not lost.

Reset
REQ-018 Asserting rst_n low SHALL immediately force state IDLE, all ready/valid outputs 0, rsp data 0, ALU port 0, latency counter 0, priority pointer to requester 0.
REQ-019 Reset during EXEC or RESP SHALL abandon the operation; no response for it SHALL ever be issued.
REQ-020 Deassertion of rst_n SHALL take effect at the next rising clk edge; the first grant is possible in that cycle.

Configuration
REQ-021 With macro ULA_ARB_RR_EN defined, arbitration SHALL be round-robin: when both request, grant the requester not served last; the pointer updates on each acceptance.
REQ-022 Without ULA_ARB_RR_EN, arbitration SHALL be fixed priority: requester 0 always wins when both request; no pointer register exists.

Verification
REQ-023 ALU_LAT=1, req0 op=0010 a=5 b=7 -> req0_ready 1 in acceptance cycle, rsp0_valid 1 one cycle later with rsp0_s=12, rsp0_z=0.
REQ-024 req1 op=0110 a=9 b=9, rsp1_ready held low 3 cycles -> rsp1_valid, rsp1_s=0, rsp1_z=1 stable all 3 cycles; returns to IDLE after ready.
REQ-025 ULA_ARB_RR_EN defined, both requesting continuously (op=0111, req0 a=-1 b=0, req1 a=3 b=2) -> grants alternate 0,1,0,1; rsp0_s=1, rsp1_s=0.
REQ-026 ULA_ARB_RR_EN undefined, both requesting continuously -> every grant to requester 0; req1_ready stays 0.
REQ-027 ALU_LAT=3, req0 op=1100 a=0 b=0 -> alu_op=1100 held 3 cycles, rsp0_s=FFFFFFFF, rsp0_z=0 on third edge after acceptance.
REQ-028 rst_n pulsed low during EXEC of req0 op=0010 a=1 b=1 -> all outputs 0 immediately, no rsp0_valid afterwards; next request proceeds normally.
